pll_dyn_cfg_ctrl: RTL and testbench
===================================

Name: pll_dyn_cfg_ctrl

Overview:
Sequencer for a single PLL instance with dynamic output-0 reconfiguration. It runs the power-up sequence (power-down pulse, then reset pulse), waits for a stable lock and gates clkout0 until lock is confirmed. It accepts runtime divider, duty and phase change requests through a req/ack handshake, applies them with a gate/reset/relock sequence, and automatically relocks after lock loss. It sits between system control logic and the PLL primitive wrapper.

Parameters:
PWD_CYC, 10, cycles pll_pwd is held high after reset
RST_CYC, 10, cycles pll_rst is held high per reset pulse
GATE_CYC, 4, cycles clkout0 stays gated before pll_rst asserts on reconfig
STABLE_CYC, 16, consecutive synced-lock-high cycles required to declare lock
LOCK_TMO, 100000, LOCKWAIT timeout in cycles
MAX_RETRY, 3, reset retries after timeout before error
DEF_ODIV, 100, reset value of dyn_odiv0
DEF_DUTY, 100, reset value of dyn_duty0
DEF_PHASE, 16, reset value of dyn_phase0

Ports:
clk  in  1  controller clock, free-running and independent of the PLL outputs
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  reconfig request; held high by the requester until cfg_ack
cfg_odiv  in  10  requested output divider
cfg_duty  in  10  requested duty setting
cfg_phase  in  13  requested phase setting
cfg_ack  out  1  1-cycle pulse: request accepted and values latched
cfg_busy  out  1  high in every state except RUN and ERR
cfg_done  out  1  1-cycle pulse on entry to RUN
cfg_err  out  1  1-cycle pulse on illegal request or retry exhaustion
lock_lost  out  1  sticky; set on lock loss in RUN, cleared by cfg_ack
pll_lock  in  1  raw PLL lock, asynchronous to clk
pll_pwd  out  1  PLL power-down
pll_rst  out  1  PLL reset
clkout0_gate  out  1  1 = clkout0 blocked
dyn_odiv0  out  10  divider to PLL
dyn_duty0  out  10  duty to PLL
dyn_phase0  out  13  phase to PLL

Behaviour:
- pll_lock passes through a 2-FF synchronizer (lock_s). All lock decisions use lock_s, so there are 2 cycles of latency.
- Reset values: state=PWRUP, pll_pwd=1, pll_rst=1, clkout0_gate=1, dyn_* = DEF_*, cfg_busy=1, cfg_ack/cfg_done/cfg_err/lock_lost=0, retry=0.
- PWRUP: pll_pwd=1 and pll_rst=1 for PWD_CYC cycles, then go to PRST.
- PRST: pll_pwd=0, pll_rst=1 for RST_CYC cycles, then go to LOCKWAIT with the stable and timeout counters cleared.
- LOCKWAIT: pll_rst=0, gate=1.
  - Stable counter increments while lock_s=1 and clears on lock_s=0.
  - Stable counter reaching STABLE_CYC: go to RUN, gate=0, cfg_done pulse, retry=0.
  - Timeout counter reaching LOCK_TMO with retry<MAX_RETRY: retry+1, go to PRST.
  - Timeout at retry==MAX_RETRY: go to ERR, cfg_err pulse.
- RUN: gate=0, busy=0.
  - Falling lock_s: lock_lost=1, gate=1 in the same cycle, go to PRST. No cfg_err is raised.
  - cfg_req=1 with legal values: cfg_ack pulse, latch the values into shadow registers, go to GATE.
  - Legal values: cfg_odiv!=0, cfg_duty!=0, cfg_duty<2*cfg_odiv. Compare at 11-bit width; no overflow.
  - cfg_req=1 with illegal values: cfg_ack pulse plus cfg_err pulse in the same cycle, stay in RUN, outputs unchanged.
  - Lock loss and cfg_req in the same cycle: lock loss wins and there is no ack. The request stays pending and is served after relock.
- GATE: gate=1 for GATE_CYC cycles. On the last cycle, copy the shadow values to dyn_*, then go to PRST. dyn_* are stable for at least 1 cycle before pll_rst rises.
- ERR: pll_rst=1, gate=1, busy=0. cfg_req is accepted with the legality check applied; a legal request acks, loads dyn_* directly and goes to PRST with retry=0.
- cfg_req outside RUN/ERR is ignored (no ack); the requester holds it.
- Asynchronous rst_n mid-sequence aborts immediately to the reset values; no partial dyn_* update is retained.
- Counters are sized with $clog2 of their parameter and do not wrap; they saturate at the terminal value.

Optional Feature:
PLL_CTRL_LOSS_CNT_EN
- Defined: adds output loss_cnt[7:0], an 8-bit saturating count of RUN lock-loss events (stays at 255). Reset to 0; not cleared by cfg_ack.
- Undefined: the port and its logic are absent; lock_lost is the only loss indication.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum (PWRUP, PRST, LOCKWAIT, RUN, GATE, ERR);
  - width constants ODIV_W=10, DUTY_W=10, PHASE_W=13;
  - a function cfg_legal(odiv, duty).
- One sub-module, pll_lock_sync: the 2-FF synchronizer plus the falling-edge detect on lock_s.

Test Plan:
- Power-up with PWD_CYC=10, RST_CYC=10, STABLE_CYC=4, lock model rising 500 ns after pll_rst falls -> pll_pwd high for 10 cycles, pll_rst high for 20 cycles, cfg_done pulses once, gate drops, dyn_odiv0=100, dyn_duty0=100, dyn_phase0=16.
- From RUN: req odiv=200, duty=200, phase=16 -> ack 1 cycle, gate high for 4 cycles, dyn_* update one cycle before pll_rst rises, relock, cfg_done, lock_lost=0.
- Illegal req odiv=50, duty=100 -> cfg_ack plus cfg_err same cycle, dyn_odiv0 stays 200, state stays RUN.
- Lock model never locks with LOCK_TMO=200, MAX_RETRY=3 -> exactly 4 pll_rst pulses, then cfg_err, ERR state, busy=0; a legal req then recovers to RUN.
- Force pll_lock low for 50 cycles in RUN with a simultaneous cfg_req -> lock_lost=1, no ack that cycle, relock, then ack is served; with PLL_CTRL_LOSS_CNT_EN, loss_cnt=1.
- Assert rst_n low during GATE -> all outputs return to reset values immediately and dyn_odiv0 reads 100.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types, widths and request legality check for the PLL sequencer.
package pll_ctrl_pkg;

   localparam int ODIV_W  = 10;
   localparam int DUTY_W  = 10;
   localparam int PHASE_W = 13;

   localparam logic [2:0] S_PWRUP    = 3'd0;
   localparam logic [2:0] S_PRST     = 3'd1;
   localparam logic [2:0] S_LOCKWAIT = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_GATE     = 3'd4;
   localparam logic [2:0] S_ERR      = 3'd5;

   // duty must stay below twice the divider; 11 bits keeps 2*odiv exact
   function automatic logic cfg_legal(
      input logic [ODIV_W-1:0] odiv,
      input logic [DUTY_W-1:0] duty
   );
      logic [ODIV_W:0] odiv2;
      logic [ODIV_W:0] duty_x;
      odiv2  = {odiv, 1'b0};
      duty_x = {1'b0, duty};
      return (odiv != '0) && (duty != '0) && (duty_x < odiv2);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the raw PLL lock plus falling-edge detect.
module pll_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic lock_raw,
   output logic lock_s,
   output logic lock_fall
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= lock_raw;
         sync <= meta;
         prev <= sync;
      end
   end

   assign lock_s    = sync;
   assign lock_fall = prev & ~sync;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL power-up, lock supervision and dynamic output-0 reconfiguration.
// Optional loss_cnt output is enabled with PLL_CTRL_LOSS_CNT_EN.
module pll_dyn_cfg_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int PWD_CYC    = 10,
   parameter int RST_CYC    = 10,
   parameter int GATE_CYC   = 4,
   parameter int STABLE_CYC = 16,
   parameter int LOCK_TMO   = 100000,
   parameter int MAX_RETRY  = 3,
   parameter int DEF_ODIV   = 100,
   parameter int DEF_DUTY   = 100,
   parameter int DEF_PHASE  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_req,
   input  logic [ODIV_W-1:0]  cfg_odiv,
   input  logic [DUTY_W-1:0]  cfg_duty,
   input  logic [PHASE_W-1:0] cfg_phase,
   output logic               cfg_ack,
   output logic               cfg_busy,
   output logic               cfg_done,
   output logic               cfg_err,
   output logic               lock_lost,
   input  logic               pll_lock,
   output logic               pll_pwd,
   output logic               pll_rst,
   output logic               clkout0_gate,
   output logic [ODIV_W-1:0]  dyn_odiv0,
   output logic [DUTY_W-1:0]  dyn_duty0,
   output logic [PHASE_W-1:0] dyn_phase0
`ifdef PLL_CTRL_LOSS_CNT_EN
   ,
   output logic [7:0]         loss_cnt
`endif
);

   localparam int M1 = (PWD_CYC > RST_CYC) ? PWD_CYC : RST_CYC;
   localparam int M2 = (M1 > GATE_CYC) ? M1 : GATE_CYC;
   localparam int SEQ_MAX = (M2 > LOCK_TMO) ? M2 : LOCK_TMO;
   localparam int CW = $clog2(SEQ_MAX + 1);
   localparam int SW = $clog2(STABLE_CYC + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_inc;
   logic [SW-1:0]      stab;
   logic [SW-1:0]      stab_inc;
   logic [RW-1:0]      retry;
   logic [ODIV_W-1:0]  sh_odiv;
   logic [DUTY_W-1:0]  sh_duty;
   logic [PHASE_W-1:0] sh_phase;
   logic               lock_s;
   logic               lock_fall;
   logic               legal;
   logic               run_loss;

   pll_lock_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .lock_raw  (pll_lock),
      .lock_s    (lock_s),
      .lock_fall (lock_fall)
   );

   assign legal    = cfg_legal(cfg_odiv, cfg_duty);
   assign cnt_inc  = (cnt == CW'(SEQ_MAX)) ? cnt : cnt + 1'b1;
   assign stab_inc = (stab == SW'(STABLE_CYC)) ? stab : stab + 1'b1;
   assign run_loss = (state == S_RUN) && lock_fall;

   assign pll_pwd      = (state == S_PWRUP);
   assign pll_rst      = (state == S_PWRUP) || (state == S_PRST) ||
                         (state == S_ERR);
   assign clkout0_gate = (state != S_RUN) || lock_fall;
   assign cfg_busy     = (state != S_RUN) && (state != S_ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_PWRUP;
         cnt        <= '0;
         stab       <= '0;
         retry      <= '0;
         sh_odiv    <= ODIV_W'(DEF_ODIV);
         sh_duty    <= DUTY_W'(DEF_DUTY);
         sh_phase   <= PHASE_W'(DEF_PHASE);
         dyn_odiv0  <= ODIV_W'(DEF_ODIV);
         dyn_duty0  <= DUTY_W'(DEF_DUTY);
         dyn_phase0 <= PHASE_W'(DEF_PHASE);
         cfg_ack    <= 1'b0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         cfg_ack  <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            S_PWRUP: begin
               if (cnt == CW'(PWD_CYC - 1)) begin
                  state <= S_PRST;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_PRST: begin
               if (cnt == CW'(RST_CYC - 1)) begin
                  state <= S_LOCKWAIT;
                  cnt   <= '0;
                  stab  <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_LOCKWAIT: begin
               stab <= lock_s ? stab_inc : '0;
               cnt  <= cnt_inc;
               if (lock_s && stab == SW'(STABLE_CYC - 1)) begin
                  state    <= S_RUN;
                  cfg_done <= 1'b1;
                  retry    <= '0;
               end else if (cnt == CW'(LOCK_TMO - 1)) begin
                  cnt <= '0;
                  if (retry == RW'(MAX_RETRY)) begin
                     state   <= S_ERR;
                     cfg_err <= 1'b1;
                  end else begin
                     retry <= retry + 1'b1;
                     state <= S_PRST;
                  end
               end
            end
            S_RUN: begin
               // lock loss beats a same-cycle request; the request stays pending
               if (lock_fall) begin
                  lock_lost <= 1'b1;
                  state     <= S_PRST;
                  cnt       <= '0;
               end else if (cfg_req) begin
                  cfg_ack   <= 1'b1;
                  lock_lost <= 1'b0;
                  if (legal) begin
                     sh_odiv  <= cfg_odiv;
                     sh_duty  <= cfg_duty;
                     sh_phase <= cfg_phase;
                     state    <= S_GATE;
                     cnt      <= '0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_GATE: begin
               // new values settle one cycle ahead of pll_rst rising
               if (cnt == CW'(GATE_CYC - 2)) begin
                  dyn_odiv0  <= sh_odiv;
                  dyn_duty0  <= sh_duty;
                  dyn_phase0 <= sh_phase;
               end
               if (cnt == CW'(GATE_CYC - 1)) begin
                  state <= S_PRST;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_ERR: begin
               if (cfg_req) begin
                  cfg_ack   <= 1'b1;
                  lock_lost <= 1'b0;
                  if (legal) begin
                     dyn_odiv0  <= cfg_odiv;
                     dyn_duty0  <= cfg_duty;
                     dyn_phase0 <= cfg_phase;
                     retry      <= '0;
                     state      <= S_PRST;
                     cnt        <= '0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_PWRUP;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef PLL_CTRL_LOSS_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt <= '0;
      end else if (run_loss && loss_cnt != 8'hff) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end
`else
   logic unused_loss;
   assign unused_loss = run_loss;
`endif

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Randomized request bench with a behavioural PLL lock model and
// a reference model of the committed divider/duty/phase settings.
module tb_pll_dyn_cfg_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cfg_req;
   logic [9:0]  cfg_odiv;
   logic [9:0]  cfg_duty;
   logic [12:0] cfg_phase;
   logic        cfg_ack;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;
   logic        lock_lost;
   logic        pll_lock;
   logic        pll_pwd;
   logic        pll_rst;
   logic        clkout0_gate;
   logic [9:0]  dyn_odiv0;
   logic [9:0]  dyn_duty0;
   logic [12:0] dyn_phase0;
`ifdef PLL_CTRL_LOSS_CNT_EN
   logic [7:0]  loss_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   int  m_odiv  = 100;
   int  m_duty  = 100;
   int  m_phase = 16;

   bit  lock_en   = 1;
   bit  force_low = 0;
   int  low_cnt   = 0;

   pll_dyn_cfg_ctrl #(
      .STABLE_CYC (4),
      .LOCK_TMO   (200),
      .MAX_RETRY  (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_req      (cfg_req),
      .cfg_odiv     (cfg_odiv),
      .cfg_duty     (cfg_duty),
      .cfg_phase    (cfg_phase),
      .cfg_ack      (cfg_ack),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .lock_lost    (lock_lost),
      .pll_lock     (pll_lock),
      .pll_pwd      (pll_pwd),
      .pll_rst      (pll_rst),
      .clkout0_gate (clkout0_gate),
      .dyn_odiv0    (dyn_odiv0),
      .dyn_duty0    (dyn_duty0),
      .dyn_phase0   (dyn_phase0)
`ifdef PLL_CTRL_LOSS_CNT_EN
      ,
      .loss_cnt     (loss_cnt)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // PLL locks 50 clk periods (500 ns) after its reset is released
   always @(posedge clk) begin
      if (pll_rst) low_cnt <= 0;
      else if (low_cnt < 1000) low_cnt <= low_cnt + 1;
   end
   assign pll_lock = lock_en && !force_low && (low_cnt >= 50);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit ref_legal(input int o, input int d);
      return (o != 0) && (d != 0) && (d < 2 * o);
   endfunction

   task automatic wait_for(input int sel, input int max_cyc, output bit seen);
      seen = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if ((sel == 0 && cfg_ack) || (sel == 1 && cfg_done) ||
             (sel == 2 && cfg_err)) begin
            seen = 1;
            break;
         end
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_pwd"}, pll_pwd, 1);
      chk({p, "_rst"}, pll_rst, 1);
      chk({p, "_gate"}, clkout0_gate, 1);
      chk({p, "_busy"}, cfg_busy, 1);
      chk({p, "_ack"}, cfg_ack, 0);
      chk({p, "_done"}, cfg_done, 0);
      chk({p, "_err"}, cfg_err, 0);
      chk({p, "_lost"}, lock_lost, 0);
      chk({p, "_odiv"}, dyn_odiv0, 100);
      chk({p, "_duty"}, dyn_duty0, 100);
      chk({p, "_phase"}, dyn_phase0, 16);
   endtask

   task automatic chk_dyn(input string p);
      chk({p, "_odiv"}, dyn_odiv0, m_odiv);
      chk({p, "_duty"}, dyn_duty0, m_duty);
      chk({p, "_phase"}, dyn_phase0, m_phase);
   endtask

   task automatic run_req(input int o, input int d, input int p);
      bit seen;
      bit leg;
      leg = ref_legal(o, d);
      cfg_req = 1; cfg_odiv = 10'(o); cfg_duty = 10'(d); cfg_phase = 13'(p);
      wait_for(0, 20, seen);
      chk("req_ack", seen, 1);
      chk("req_err", cfg_err, !leg);
      cfg_req = 0;
      if (leg) begin
         m_odiv = o; m_duty = d; m_phase = p;
         wait_for(1, 400, seen);
         chk("req_done", seen, 1);
         chk_dyn("req");
         chk("req_gate", clkout0_gate, 0);
         chk("req_lost", lock_lost, 0);
      end else begin
         chk_dyn("ill");
         chk("ill_busy", cfg_busy, 0);
         chk("ill_gate", clkout0_gate, 0);
      end
      @(negedge clk);
      chk("req_run", pll_rst, 0);
   endtask

   initial begin
      bit seen;
      int n_pwd, n_rst, dyn_idx, rst_idx, n_gate, n_ack, n_err, n_fall;
      bit prev_rst;
      int o, d;
      cfg_req = 0; cfg_odiv = 0; cfg_duty = 0; cfg_phase = 0;
      rst_n = 1;
      #2 rst_n = 0;
      #1 chk_reset("rst");
      @(negedge clk); @(negedge clk);
      rst_n = 1;

      n_pwd = 0; n_rst = 0;
      for (int i = 0; i < 100; i++) begin
         if (pll_pwd) n_pwd++;
         if (pll_rst) n_rst++;
         if (!pll_rst) break;
         @(negedge clk);
      end
      chk("pwd_cycles", n_pwd, 10);
      chk("rst_cycles", n_rst, 20);
      wait_for(1, 300, seen);
      chk("pwrup_done", seen, 1);
      chk_dyn("pwrup");
      chk("pwrup_gate", clkout0_gate, 0);
      @(negedge clk);
      chk("done_pulse", cfg_done, 0);

      cfg_req = 1; cfg_odiv = 200; cfg_duty = 200; cfg_phase = 16;
      wait_for(0, 20, seen);
      chk("d_ack", seen, 1);
      chk("d_err", cfg_err, 0);
      cfg_req = 0;
      dyn_idx = -1; rst_idx = -1; n_gate = 0;
      for (int i = 0; i < 20; i++) begin
         if (dyn_idx < 0 && dyn_odiv0 == 200) dyn_idx = i;
         if (pll_rst) begin
            rst_idx = i;
            break;
         end
         if (clkout0_gate) n_gate++;
         @(negedge clk);
      end
      chk("d_gate_cyc", n_gate, 4);
      chk("d_dyn_lead", rst_idx - dyn_idx, 1);
      m_odiv = 200; m_duty = 200; m_phase = 16;
      wait_for(1, 400, seen);
      chk("d_done", seen, 1);
      chk_dyn("d");
      chk("d_lost", lock_lost, 0);
      @(negedge clk);

      run_req(50, 100, 7);
      chk("ill_odiv", dyn_odiv0, 200);

      for (int k = 0; k < 12; k++) begin
         o = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
         d = ($urandom_range(0, 7) == 0) ? 0 :
             int'($urandom_range(1, (2 * o + 40 > 1023) ? 1023 : 2 * o + 40));
         run_req(o, d, int'($urandom_range(0, 8191)));
      end

      force_low = 1;
      @(negedge clk); @(negedge clk);
      chk("loss_gate", clkout0_gate, 1);
      cfg_req = 1; cfg_odiv = 300; cfg_duty = 300; cfg_phase = 5;
      @(negedge clk);
      chk("loss_noack", cfg_ack, 0);
      chk("loss_lost", lock_lost, 1);
      chk("loss_rst", pll_rst, 1);
      n_ack = 0; n_err = 0;
      for (int i = 0; i < 47; i++) begin
         @(negedge clk);
         if (cfg_ack) n_ack++;
         if (cfg_err) n_err++;
      end
      chk("loss_acks", n_ack, 0);
      chk("loss_errs", n_err, 0);
      force_low = 0;
      wait_for(1, 400, seen);
      chk("loss_relock", seen, 1);
      wait_for(0, 20, seen);
      chk("loss_ack", seen, 1);
      chk("loss_ack_err", cfg_err, 0);
      chk("loss_clr", lock_lost, 0);
      cfg_req = 0;
`ifdef PLL_CTRL_LOSS_CNT_EN
      chk("loss_cnt", loss_cnt, 1);
`endif
      m_odiv = 300; m_duty = 300; m_phase = 5;
      wait_for(1, 400, seen);
      chk("loss_done", seen, 1);
      chk_dyn("loss");
      @(negedge clk);

      lock_en = 0;
      rst_n = 0;
      m_odiv = 100; m_duty = 100; m_phase = 16;
      @(negedge clk);
      rst_n = 1;
      n_fall = 0; prev_rst = pll_rst; seen = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (prev_rst && !pll_rst) n_fall++;
         prev_rst = pll_rst;
         if (cfg_err) begin
            seen = 1;
            break;
         end
      end
      chk("tmo_err", seen, 1);
      chk("tmo_pulses", n_fall, 4);
      chk("err_busy", cfg_busy, 0);
      chk("err_rst", pll_rst, 1);
      chk("err_gate", clkout0_gate, 1);
      @(negedge clk);
      cfg_req = 1; cfg_odiv = 0; cfg_duty = 5; cfg_phase = 1;
      wait_for(0, 20, seen);
      chk("err_ill_ack", seen, 1);
      chk("err_ill_err", cfg_err, 1);
      cfg_req = 0;
      @(negedge clk);
      chk("err_stay", cfg_busy, 0);
      chk_dyn("err_ill");
      lock_en = 1;
      cfg_req = 1; cfg_odiv = 123; cfg_duty = 200; cfg_phase = 4095;
      wait_for(0, 20, seen);
      chk("err_ack", seen, 1);
      chk("err_ack_err", cfg_err, 0);
      m_odiv = 123; m_duty = 200; m_phase = 4095;
      chk_dyn("err_load");
      cfg_req = 0;
      wait_for(1, 400, seen);
      chk("err_recover", seen, 1);
      chk_dyn("err_run");
      @(negedge clk);

      cfg_req = 1; cfg_odiv = 77; cfg_duty = 100; cfg_phase = 9;
      wait_for(0, 20, seen);
      chk("g_ack", seen, 1);
      cfg_req = 0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("g_loaded", dyn_odiv0, 77);
      chk("g_gate", clkout0_gate, 1);
      rst_n = 0;
      m_odiv = 100; m_duty = 100; m_phase = 16;
      #1 chk_reset("g_rst");
      @(negedge clk);
      rst_n = 1;
      wait_for(1, 400, seen);
      chk("g_pwrup", seen, 1);
      chk_dyn("g_pwrup");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
